// File: rtl/digit_glyph_streamer.sv
// Renders a decimal digit as an 11x11 seven-segment RGB glyph streamed in raster order over valid/ready.
// Optional GLYPH_COUNT_EN adds a 16-bit count of completed glyphs.
module digit_glyph_streamer #(
    parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR = 24'h000000,
    parameter int          SIZE     = 11
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        start,
    input  logic [3:0]  digit,
    output logic        busy,
    output logic        err,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        done
`ifdef GLYPH_COUNT_EN
    ,
    output logic [15:0] glyph_count
`endif
);

    generate
        if (SIZE != 11) begin : g_size_check
            $error("digit_glyph_streamer: SIZE must be 11");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  col_q, col_d;
    logic [3:0]  digit_q, digit_d;
    logic [23:0] data_q, data_d;
    logic        sof_q, sof_d;
    logic        eol_q, eol_d;
    logic        err_q, err_d;
    logic [3:0]  next_row, next_col;

    // Segment bits are {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_map(input logic [3:0] d);
        case (d)
            4'd0:    seg_map = 7'b0111111;
            4'd1:    seg_map = 7'b0000110;
            4'd2:    seg_map = 7'b1011011;
            4'd3:    seg_map = 7'b1001111;
            4'd4:    seg_map = 7'b1100110;
            4'd5:    seg_map = 7'b1101101;
            4'd6:    seg_map = 7'b1111101;
            4'd7:    seg_map = 7'b0000111;
            4'd8:    seg_map = 7'b1111111;
            4'd9:    seg_map = 7'b1101111;
            default: seg_map = 7'b0000000;
        endcase
    endfunction

    function automatic logic [23:0] pixel_color(input logic [3:0] d, input logic [3:0] r,
                                                input logic [3:0] c);
        logic [6:0] seg;
        logic       lit;
        logic       mid_col, top_row, bot_row;
        seg     = seg_map(d);
        lit     = 1'b0;
        mid_col = (c >= 4'd1) && (c <= 4'd9);
        top_row = (r >= 4'd1) && (r <= 4'd4);
        bot_row = (r >= 4'd6) && (r <= 4'd9);
        if (mid_col && r == 4'd0)  lit = seg[0];
        if (mid_col && r == 4'd5)  lit = seg[6];
        if (mid_col && r == 4'd10) lit = seg[3];
        if (c == 4'd10 && top_row) lit = seg[1];
        if (c == 4'd10 && bot_row) lit = seg[2];
        if (c == 4'd0 && bot_row)  lit = seg[4];
        if (c == 4'd0 && top_row)  lit = seg[5];
        pixel_color = lit ? FG_COLOR : BG_COLOR;
    endfunction

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        digit_d  = digit_q;
        data_d   = data_q;
        sof_d    = sof_q;
        eol_d    = eol_q;
        err_d    = 1'b0;
        next_row = row_q;
        next_col = col_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (digit > 4'd9) begin
                        err_d = 1'b1;
                    end else begin
                        digit_d = digit;
                        row_d   = 4'd0;
                        col_d   = 4'd0;
                        data_d  = pixel_color(digit, 4'd0, 4'd0);
                        sof_d   = 1'b1;
                        eol_d   = 1'b0;
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (pix_ready) begin
                    if (row_q == 4'd10 && col_q == 4'd10) begin
                        row_d   = 4'd0;
                        col_d   = 4'd0;
                        data_d  = 24'd0;
                        sof_d   = 1'b0;
                        eol_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        if (col_q == 4'd10) begin
                            next_col = 4'd0;
                            next_row = row_q + 4'd1;
                        end else begin
                            next_col = col_q + 4'd1;
                        end
                        row_d  = next_row;
                        col_d  = next_col;
                        data_d = pixel_color(digit_q, next_row, next_col);
                        sof_d  = 1'b0;
                        eol_d  = (next_col == 4'd10);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            row_q   <= 4'd0;
            col_q   <= 4'd0;
            digit_q <= 4'd0;
            data_q  <= 24'd0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            digit_q <= digit_d;
            data_q  <= data_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q == STREAM);
    assign pix_valid = (state_q == STREAM);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign pix_data  = data_q;
    assign pix_sof   = sof_q;
    assign pix_eol   = eol_q;

`ifdef GLYPH_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == DONE) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) cnt_q <= 16'd0;
        else         cnt_q <= cnt_d;
    end

    assign glyph_count = cnt_q;
`endif

endmodule
